// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes the immediate, format and illegal flag of a
// 32-bit instruction, one result per cycle, with an optional skid entry behind the output stage.
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 1,
  parameter int SKID        = 1,
  parameter int TAG_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       sel_ext,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_R    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
  localparam logic [2:0] FMT_NONE = 3'd7;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift_f3;
  logic [2:0]      dec_fmt;
  logic            dec_ill;
  logic [31:0]     imm32;
  logic [XLEN-1:0] dec_imm;

  assign opcode      = instr[6:0];
  assign funct3      = instr[14:12];
  assign is_shift_f3 = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    dec_fmt = FMT_NONE;
    dec_ill = 1'b1;
    if (AUTO_DECODE != 0) begin
      case (opcode)
        7'b0000011, 7'b1100111, 7'b1110011: dec_fmt = FMT_I;
        7'b0010011: dec_fmt = is_shift_f3 ? FMT_SH : FMT_I;
        7'b0011011: if (XLEN == 64) dec_fmt = is_shift_f3 ? FMT_SH : FMT_I;
        7'b0100011: dec_fmt = FMT_S;
        7'b1100011: dec_fmt = FMT_B;
        7'b0110111, 7'b0010111: dec_fmt = FMT_U;
        7'b1101111: dec_fmt = FMT_J;
        7'b0110011: dec_fmt = FMT_R;
        7'b0111011: if (XLEN == 64) dec_fmt = FMT_R;
        default:    dec_fmt = FMT_NONE;
      endcase
      // Compressed encodings are not handled by this decoder.
      if (instr[1:0] != 2'b11) dec_fmt = FMT_NONE;
      dec_ill = (dec_fmt == FMT_NONE);
    end else begin
      dec_fmt = sel_ext;
      dec_ill = (sel_ext == FMT_R) || (sel_ext == FMT_SH) || (sel_ext == FMT_NONE);
    end

    imm32 = '0;
    case (dec_fmt)
      FMT_I:  imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:  imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:  imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:  imm32 = {instr[31:12], 12'b0};
      FMT_J:  imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      // RV64 OP-IMM shifts carry a 6-bit shamt; the 32-bit word variants keep 5 bits.
      FMT_SH: imm32 = ((XLEN == 64) && (opcode == 7'b0010011)) ? {26'b0, instr[25:20]}
                                                               : {27'b0, instr[24:20]};
      default: imm32 = '0;
    endcase
    if (dec_ill) imm32 = '0;
  end

  assign dec_imm = XLEN'($signed(imm32));

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [2:0]       out_fmt_q, out_fmt_d;
  logic             out_ill_q, out_ill_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [2:0]       skid_fmt_q, skid_fmt_d;
  logic             skid_ill_q, skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             out_free;
  logic             in_fire;

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (SKID != 0) ? !skid_valid_q : out_free;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    if (out_free) begin
      if (skid_valid_q) begin
        // in_ready is low while the skid entry is occupied, so nothing new arrives here.
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_ill_d    = skid_ill_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) begin
          out_imm_d = dec_imm;
          out_fmt_d = dec_fmt;
          out_ill_d = dec_ill;
          out_tag_d = in_tag;
        end
      end
    end else if (in_fire && (SKID != 0)) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_fmt_d   = dec_fmt;
      skid_ill_d   = dec_ill;
      skid_tag_d   = in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= '0;
      out_ill_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign imm         = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (default, RV64 single-stage, explicit select)
// checked against an arithmetic reference model, plus directed backpressure and reset sequences.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  sel_ext;
  logic [31:0] in_tag;

  always #5 clk = ~clk;

  logic        a_in_ready, a_out_valid, a_ill;
  logic [31:0] a_imm, a_tag;
  logic [2:0]  a_fmt;
  logic        w_in_ready, w_out_valid, w_ill;
  logic [63:0] w_imm;
  logic [31:0] w_tag;
  logic [2:0]  w_fmt;
  logic        x_in_ready, x_out_valid, x_ill;
  logic [31:0] x_imm, x_tag;
  logic [2:0]  x_fmt;

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1), .SKID(1), .TAG_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .instr(instr),
    .sel_ext(sel_ext), .in_tag(in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .imm(a_imm), .out_fmt(a_fmt), .out_illegal(a_ill), .out_tag(a_tag));

  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1), .SKID(0), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .instr(instr),
    .sel_ext(sel_ext), .in_tag(in_tag), .out_valid(w_out_valid), .out_ready(out_ready),
    .imm(w_imm), .out_fmt(w_fmt), .out_illegal(w_ill), .out_tag(w_tag));

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0), .SKID(1), .TAG_W(32)) dutx (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(x_in_ready), .instr(instr),
    .sel_ext(sel_ext), .in_tag(in_tag), .out_valid(x_out_valid), .out_ready(out_ready),
    .imm(x_imm), .out_fmt(x_fmt), .out_illegal(x_ill), .out_tag(x_tag));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: immediates computed from the field rules with signed arithmetic.
  function automatic void model(input logic [31:0] ins, input logic [2:0] sel, input bit auto_dec,
                                input bit x64, output logic [2:0] fmt, output logic ill,
                                output logic [63:0] imm_o);
    longint s, v;
    logic [6:0] op;
    logic [2:0] f3;
    s  = longint'($signed(ins));
    op = ins[6:0];
    f3 = ins[14:12];
    if (auto_dec) begin
      fmt = 3'd7;
      if (op == 7'h03 || op == 7'h67 || op == 7'h73) fmt = 3'd0;
      else if (op == 7'h13 || (x64 && op == 7'h1B)) fmt = (f3 == 3'd1 || f3 == 3'd5) ? 3'd6 : 3'd0;
      else if (op == 7'h23) fmt = 3'd1;
      else if (op == 7'h63) fmt = 3'd2;
      else if (op == 7'h37 || op == 7'h17) fmt = 3'd3;
      else if (op == 7'h6F) fmt = 3'd4;
      else if (op == 7'h33 || (x64 && op == 7'h3B)) fmt = 3'd5;
      if (ins[1:0] != 2'b11) fmt = 3'd7;
      ill = (fmt == 3'd7);
    end else begin
      fmt = sel;
      ill = (sel >= 3'd5);
    end
    case (fmt)
      3'd0: v = s >>> 20;
      3'd1: v = ((s >>> 25) * 32) + longint'(ins[11:7]);
      3'd2: v = ((s >>> 31) * 4096) + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                + longint'(ins[11:8]) * 2;
      3'd3: v = (s >>> 12) * 4096;
      3'd4: v = ((s >>> 31) * 1048576) + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                + longint'(ins[30:21]) * 2;
      3'd6: v = longint'(ins[25:20]) % ((x64 && op != 7'h1B) ? 64 : 32);
      default: v = 0;
    endcase
    if (ill) v = 0;
    imm_o = v;
  endfunction

  // Checks the result presented one cycle after an item (ins, sel, tag) was offered stall-free.
  task automatic chk_all(input string tname, input logic [31:0] ins, input logic [2:0] sel,
                         input logic [31:0] tag);
    logic [2:0]  f;
    logic        il;
    logic [63:0] m;
    model(ins, sel, 1'b1, 1'b0, f, il, m);
    chk({tname, ".a_valid"}, a_out_valid, 1);
    chk({tname, ".a_imm"}, a_imm, m[31:0]);
    chk({tname, ".a_fmt"}, a_fmt, f);
    chk({tname, ".a_ill"}, a_ill, il);
    chk({tname, ".a_tag"}, a_tag, tag);
    model(ins, sel, 1'b1, 1'b1, f, il, m);
    chk({tname, ".w_valid"}, w_out_valid, 1);
    chk({tname, ".w_imm"}, w_imm, m);
    chk({tname, ".w_fmt"}, w_fmt, f);
    chk({tname, ".w_ill"}, w_ill, il);
    chk({tname, ".w_tag"}, w_tag, tag);
    model(ins, sel, 1'b0, 1'b0, f, il, m);
    chk({tname, ".x_valid"}, x_out_valid, 1);
    chk({tname, ".x_imm"}, x_imm, m[31:0]);
    chk({tname, ".x_fmt"}, x_fmt, f);
    chk({tname, ".x_ill"}, x_ill, il);
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] exp_imm;
    logic [2:0]  exp_fmt;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops[13];
    logic [31:0] ins;
    logic v;

    vecs[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 1'b0};
    vecs[1] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd1, 1'b0};
    vecs[2] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 1'b0};
    vecs[3] = '{32'h123450B7, 32'h12345000, 3'd3, 1'b0};
    vecs[4] = '{32'h008000EF, 32'h00000008, 3'd4, 1'b0};
    vecs[5] = '{32'h4041D093, 32'h00000004, 3'd6, 1'b0};
    vecs[6] = '{32'h002081B3, 32'h00000000, 3'd5, 1'b0};
    vecs[7] = '{32'h0000007F, 32'h00000000, 3'd7, 1'b1};
    vecs[8] = '{32'h00000001, 32'h00000000, 3'd7, 1'b1};
    vecs[9] = '{32'h02809093, 32'h00000008, 3'd6, 1'b0};
    ops = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33,
            7'h3B, 7'h7F};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = '0; sel_ext = '0; in_tag = '0;
    tick(); tick();
    chk("rst.valid", a_out_valid, 0);
    chk("rst.imm", a_imm, 0);
    chk("rst.fmt", a_fmt, 0);
    chk("rst.ill", a_ill, 0);
    chk("rst.tag", a_tag, 0);
    #2 rst = 1'b0;
    tick();
    chk("rst.in_ready", a_in_ready, 1);
    chk("rst.valid_after", a_out_valid, 0);

    // Table: back-to-back stall-free, explicit select mirrors the expected format.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; instr = vecs[i].ins; sel_ext = vecs[i].exp_fmt; in_tag = 32'h100 + i;
      tick();
      chk($sformatf("vec%0d.imm", i), a_imm, vecs[i].exp_imm);
      chk($sformatf("vec%0d.fmt", i), a_fmt, vecs[i].exp_fmt);
      chk($sformatf("vec%0d.ill", i), a_ill, vecs[i].exp_ill);
      chk_all($sformatf("vec%0d", i), instr, sel_ext, in_tag);
      $display("vec %0d instr=%08h imm=%08h fmt=%0d ill=%0d", i, instr, a_imm, a_fmt, a_ill);
    end

    // RV64 directed: lui sign extension and 6-bit shamt.
    instr = 32'h800000B7; in_tag = 32'hA1;
    tick();
    chk("x64.lui", w_imm, 64'hFFFFFFFF80000000);
    instr = 32'h02809093; in_tag = 32'hA2;
    tick();
    chk("x64.slli40", w_imm, 64'd40);
    chk("x64.slli40_fmt", w_fmt, 3'd6);

    // Random stimulus, out_ready held high so all three configurations run in lockstep.
    for (int i = 0; i < 300; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 12)];
      v = ($urandom_range(0, 3) != 0);
      in_valid = v; instr = ins; sel_ext = 3'($urandom_range(0, 7)); in_tag = $urandom;
      tick();
      if (v) begin
        chk_all($sformatf("rnd%0d", i), instr, sel_ext, in_tag);
      end else begin
        chk($sformatf("rnd%0d.a_idle", i), a_out_valid, 0);
        chk($sformatf("rnd%0d.w_idle", i), w_out_valid, 0);
      end
      $display("rnd %0d v=%0d instr=%08h imm=%08h fmt=%0d", i, v, instr, a_imm, a_fmt);
    end

    // Backpressure: three back-to-back items against a stalled consumer.
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFFF00093; in_tag = 32'd1;
    tick();
    chk("bp.v1", a_out_valid, 1);
    chk("bp.tag1", a_tag, 1);
    chk("bp.rdy1", a_in_ready, 1);
    instr = 32'h123450B7; in_tag = 32'd2;
    tick();
    chk("bp.rdy2", a_in_ready, 0);
    chk("bp.hold_tag", a_tag, 1);
    chk("bp.w_rdy", w_in_ready, 0);
    instr = 32'h008000EF; in_tag = 32'd3;
    tick();
    chk("bp.rdy3", a_in_ready, 0);
    chk("bp.hold_imm", a_imm, 32'hFFFFFFFF);
    chk("bp.hold_tag2", a_tag, 1);
    out_ready = 1'b1;
    tick();
    chk("bp.out2_tag", a_tag, 2);
    chk("bp.out2_imm", a_imm, 32'h12345000);
    chk("bp.rdy_back", a_in_ready, 1);
    tick();
    chk("bp.out3_v", a_out_valid, 1);
    chk("bp.out3_tag", a_tag, 3);
    chk("bp.out3_imm", a_imm, 32'h8);
    in_valid = 1'b0;
    tick();
    chk("bp.drained", a_out_valid, 0);
    $display("backpressure sequence done");

    // Asynchronous reset with both entries full.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'hFE112E23; in_tag = 32'h55;
    tick();
    instr = 32'hFE000EE3; in_tag = 32'h66;
    tick();
    chk("ar.full_rdy", a_in_ready, 0);
    chk("ar.full_v", a_out_valid, 1);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar.valid", a_out_valid, 0);
    chk("ar.imm", a_imm, 0);
    chk("ar.tag", a_tag, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    chk("ar.in_ready", a_in_ready, 1);
    chk("ar.no_out", a_out_valid, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ar.stale%0d", i), a_out_valid, 0);
    end
    in_valid = 1'b1; instr = 32'h4041D093; in_tag = 32'h77;
    tick();
    chk("ar.fresh_tag", a_tag, 32'h77);
    chk("ar.fresh_imm", a_imm, 32'h4);
    in_valid = 1'b0;
    tick();
    chk("ar.fresh_once", a_out_valid, 0);
    $display("async reset sequence done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
